// File: rtl/rom_readback.sv
// Streams a byte range of the cartridge ROM back out of SDRAM, one byte per beat,
// keeping a Genesis-style 16-bit word checksum of every byte accepted.
module rom_readback #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  output logic [ADDR_W-2:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  input  logic [15:0]       mem_dout,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [15:0]       word;
  logic [7:0]        cur_byte;
  logic [15:0]       byte_term;
  logic              accept;
  logic              last_beat;

  assign mem_we = 1'b0;
  assign mem_be = 2'b11;

  // Loader stores big-endian: even byte in the high half of the word.
  assign cur_byte  = addr[0] ? word[7:0] : word[15:8];
  assign byte_term = addr[0] ? {8'h00, out_data} : {out_data, 8'h00};
  assign accept    = out_valid && out_ready;
  assign last_beat = (remaining == LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= length;
            checksum  <= '0;
            busy      <= 1'b1;
            state     <= (length == '0) ? S_FIN : S_REQ;
          end
        end
        S_REQ: begin
          mem_addr <= addr[ADDR_W-1:1];
          mem_req  <= ~mem_req;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ack == mem_req) begin
            word  <= mem_dout;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= cur_byte;
          end else if (accept) begin
            checksum  <= checksum + byte_term;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (last_beat) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_FIN;
            end else if (addr[0]) begin
              out_valid <= 1'b0;
              state     <= S_REQ;
            end else begin
              out_data <= word[7:0];
            end
          end
        end
        S_FIN: begin
          // Zero-length starts arrive here with done still low.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_readback.sv
// Directed bench for rom_readback with a toggle-handshake SDRAM model
// and a byte scoreboard.
module tb_rom_readback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [21:0] start_addr = '0;
  logic [22:0] length = '0;
  logic        busy, done, mem_req, mem_we, out_valid;
  logic        out_ready = 1'b1;
  logic        mem_ack;
  logic [15:0] checksum, mem_dout;
  logic [20:0] mem_addr;
  logic [1:0]  mem_be;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  rom_readback dut (
    .clk(clk), .reset(reset), .start(start),
    .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_we(mem_we), .mem_be(mem_be), .mem_dout(mem_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [15:0] mem [0:15];
  int          lat_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ack  <= 1'b0;
      mem_dout <= '0;
      lat_cnt  <= 0;
    end else if (mem_req != mem_ack) begin
      if (lat_cnt == 2) begin
        mem_ack  <= mem_req;
        mem_dout <= mem[mem_addr[3:0]];
        lat_cnt  <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  logic [7:0]  obs_b [0:255];
  logic [20:0] req_a [0:63];
  int          obs_n = 0;
  int          req_n = 0;
  int          done_n = 0;
  logic        req_prev = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready && obs_n < 256) begin
      obs_b[obs_n] <= out_data;
      obs_n <= obs_n + 1;
    end
    if (mem_req !== req_prev) begin
      if (req_n < 64) req_a[req_n] <= mem_addr;
      req_n <= req_n + 1;
    end
    req_prev <= mem_req;
    if (done) done_n <= done_n + 1;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [15:0] exp_sum;
  int         exp_words, ob0, rq0, dn0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input logic [21:0] a, input logic [22:0] n);
    logic [21:0] p;
    logic [15:0] w;
    logic [7:0]  b;
    exp_sum = '0;
    p = a;
    for (int i = 0; i < int'(n); i++) begin
      w = mem[p[4:1]];
      b = p[0] ? w[7:0] : w[15:8];
      exp_q.push_back(b);
      exp_sum = exp_sum + (p[0] ? {8'h00, b} : {b, 8'h00});
      p = p + 22'd1;
    end
    exp_words = (n == 0) ? 0 :
      ((int'(a) + int'(n) - 1) >> 1) - (int'(a) >> 1) + 1;
    ob0 = obs_n;
    rq0 = req_n;
    dn0 = done_n;
    start_addr = a;
    length = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    int cnt;
    cnt = obs_n - ob0;
    check({tag, "_count"}, 32'(cnt), 32'(exp_q.size()));
    for (int i = 0; i < cnt && exp_q.size() > 0; i++)
      check({tag, "_byte"}, 32'(obs_b[(ob0 + i) % 256]),
            32'(exp_q.pop_front()));
    exp_q.delete();
    check({tag, "_sum"}, 32'(checksum), 32'(exp_sum));
    check({tag, "_reqs"}, 32'(req_n - rq0), 32'(exp_words));
    check({tag, "_dones"}, 32'(done_n - dn0), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h1111);
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    mem[2] = 16'h5678;
    mem[3] = 16'h9A0F;
    mem[4] = 16'hC3E1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sum", 32'(checksum), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("tie_we", 32'(mem_we), 32'd0);
    check("tie_be", 32'(mem_be), 32'd3);
    reset = 1'b0;
    @(posedge clk);
    #1;

    start_xfer(22'd0, 23'd4);
    check("aln_busy_rise", 32'(busy), 32'd1);
    wait_done("aln");
    check("aln_sum_const", 32'(checksum), 32'h0000BE01);
    check_stream("aln");

    start_xfer(22'd1, 23'd2);
    wait_done("unal");
    check("unal_addr0", 32'(req_a[rq0 % 64]), 32'd0);
    check("unal_addr1", 32'(req_a[(rq0 + 1) % 64]), 32'd1);
    check_stream("unal");

    out_ready = 1'b0;
    start_xfer(22'd0, 23'd4);
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h12);
    end
    check("bp_reqs_stall", 32'(req_n - rq0), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("bp");
    check_stream("bp");

    start_xfer(22'd3, 23'd0);
    check("zl_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("zl_done", 32'(done), 32'd1);
    check("zl_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("zl_done_fall", 32'(done), 32'd0);
    @(negedge clk);
    check("zl_reqs", 32'(req_n - rq0), 32'd0);
    check("zl_sum", 32'(checksum), 32'd0);
    exp_q.delete();

    start_xfer(22'd4, 23'd6);
    repeat (3) @(posedge clk);
    #1;
    start_addr = 22'd9;
    length = 23'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("sb");
    check_stream("sb");

    start_xfer(22'd2, 23'd4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_valid", 32'(out_valid), 32'd0);
    check("rm_req", 32'(mem_req), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    start_xfer(22'd6, 23'd2);
    wait_done("rm");
    check_stream("rm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_readback.md
# rom_readback

Reads a byte range of the loaded cartridge ROM back out of SDRAM and streams it to the iosys side, one byte per beat. It is the reader counterpart of the top-level ROM loader, which writes bytes big-endian: even byte address to bits 15:8, odd byte address to bits 7:0. It connects to a spare toggle-handshake SDRAM port and is used for ROM verification, header parsing and checksum reporting to the menu CPU. It also keeps a Genesis-style 16-bit word checksum of everything it streams.

## Interface
Parameters:
- ADDR_W, 22 — byte address width; 4MB window, matching the loader.
- LEN_W, 23 — byte length width; allows a full 4MB transfer.

Ports:
- clk  in  1  — system clock, clk_sys domain.
- reset  in  1  — asynchronous, active-high reset.
- start  in  1  — one-cycle start pulse; sampled only in IDLE.
- start_addr  in  ADDR_W  — first byte address.
- length  in  LEN_W  — number of bytes to stream.
- busy  out  1  — transfer in progress.
- done  out  1  — one-cycle pulse after the last byte is accepted.
- checksum  out  16  — running word sum; valid when done pulses; held until the next accepted start.
- mem_addr  out  ADDR_W-1  — SDRAM word address, bits [ADDR_W-1:1].
- mem_req  out  1  — request toggle.
- mem_ack  in  1  — acknowledge toggle from SDRAM.
- mem_we  out  1  — tied 0.
- mem_be  out  2  — tied 2'b11.
- mem_dout  in  16  — read data; valid in the cycle mem_ack becomes equal to mem_req.
- out_data  out  8  — streamed byte.
- out_valid  out  1  — byte available.
- out_ready  in  1  — consumer accepts the byte when out_valid && out_ready.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, EMIT, FIN.
- IDLE:
  - start loads addr ← start_addr, remaining count ← length, and clears checksum.
  - length == 0: go to FIN; no memory request is issued.
  - Otherwise go to REQ.
  - start outside IDLE is ignored.
- REQ:
  - Drive mem_addr ← addr[ADDR_W-1:1] and toggle mem_req.
  - Go to WAIT.
- WAIT:
  - Stay while mem_ack != mem_req.
  - When they are equal, latch mem_dout into the word register and go to EMIT.
- EMIT:
  - If addr[0] == 0: present word[15:8] and add {byte, 8'h00} to checksum.
  - If addr[0] == 1: present word[7:0] and add {8'h00, byte} to checksum.
  - On each accept: addr += 1 and remaining -= 1.
  - After an accept, remaining == 0 → FIN.
  - After an accept, the new addr[0] == 0 (word boundary crossed) → REQ.
  - Otherwise stay in EMIT and present the low byte of the same word.
- FIN: pulse done for one cycle, then return to IDLE.
- Odd start_addr: the first fetched word emits only its low byte.
- Odd end address: the last word emits only its high byte.
- Checksum arithmetic:
  - Sums are modulo 2^16.
  - Each byte is accumulated exactly once, at the moment it is accepted.
  - For an even start and even length this equals the standard Genesis sum of big-endian words.
- Address arithmetic wraps modulo 2^ADDR_W; there is no error flag.
- Reset mid-transfer:
  - All state returns to reset values immediately and any outstanding SDRAM response is abandoned.
  - The SDRAM port's ack tracking must be reset by the same reset.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, out_valid = 0
  - out_data = 0, checksum = 0
  - mem_req = 0, mem_addr = 0
- busy rises in the cycle after an accepted start. It falls in the same cycle done pulses.
- Start to first request: start is sampled at edge 0; mem_req toggles and mem_addr is valid after edge 1.
- Response: if ack equality is first seen at edge N, out_valid is high after edge N+1.
- Throughput with no backpressure:
  - The two bytes of a word are consecutive cycles.
  - A word boundary costs REQ (1 cycle) + SDRAM latency + 1 cycle.
- out_valid and out_data are held stable while out_ready is low. out_valid never drops without an accept.
- done and checksum: done is high the cycle after the last accept. checksum already includes the last byte in that cycle.
- length == 0: done pulses 2 cycles after start. No mem_req toggle occurs.
- At most one SDRAM request is outstanding at any time.

## Test plan
- Aligned read: memory words 0x1234, 0xABCD at word addresses 0 and 1; start_addr = 0, length = 4, out_ready = 1 → bytes 12 34 AB CD; exactly 2 mem_req toggles; checksum = 0xBE01; one done pulse.
- Unaligned read: same memory; start_addr = 1, length = 2 → bytes 34 AB; first mem_addr = 0, second mem_addr = 1; checksum = 0x0034 + 0xAB00 = 0xAB34.
- Backpressure: out_ready low for 5 cycles while byte 0x12 is presented → out_valid and out_data held stable; no extra mem_req toggle; the output sequence is unchanged.
- Zero length: start with length = 0 → done 2 cycles after start; mem_req unchanged; checksum = 0.
- Start while busy: pulse start with new arguments mid-transfer → ignored; the original stream completes unchanged.
- Reset mid-transfer: assert reset while in WAIT → busy, out_valid and mem_req go to 0 asynchronously; after release, a new start of 2 bytes completes correctly.
